mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the CacheReq/CacheResp protocol; the far end of the page-table walker's memreq/memresp.
//   Accepts one request at a time, serves it from an internal word RAM after a fixed latency, returns exactly one response.
//   Sits below PTWs/caches as the backing store for sim and FPGA builds, and generates access faults for bad addresses.
// PARAMETERS
//   ADDR_BASE   32'h8000_0000  byte address of word 0
//   WORD_COUNT  4096           RAM depth in 32-bit words; power of two, >=2
//   LATENCY     2              cycles from accept edge to resp.valid; >=1
// PORTS
//   clk        input   1            clock
//   reset_n    input   1            one clock; reset is synchronous and active-low
//   req        inout   CacheReq     ready (out), valid/addr[31:0]/wen/wdata[31:0] (in)
//   resp       inout   CacheResp    valid/rdata[31:0]/error/errty (all out); no backpressure
// BEHAVIOUR
//   - States: IDLE, WAIT, RESP. req.ready = (state==IDLE); resp.valid = (state==RESP).
//   - Reset (reset_n==0 at edge): state<=IDLE, count<=0, resp.rdata<=0, resp.error<=0, resp.errty<=FE_ACCESS_FAULT.
//     req.ready=1 and resp.valid=0 in the first cycle after reset.
//   - IDLE: on req.valid (ready is 1), latch addr/wen/wdata.
//     Go to RESP if LATENCY==1, else WAIT with count<=LATENCY-2.
//   - WAIT: count==0 -> RESP, else count<=count-1. req.ready stays 0; req.valid is ignored.
//   - Timing: accept at edge N -> resp.valid high for exactly one cycle, in the cycle after edge N+LATENCY-1.
//   - Fault check on latched addr:
//     * off = addr-ADDR_BASE (32-bit unsigned; wrap below base gives a huge value -> fault).
//     * Fault if addr[1:0]!=0 or off>=WORD_COUNT*4.
//     * Fault response: error=1, errty=FE_ACCESS_FAULT, rdata=0, RAM unchanged.
//   - Read OK: rdata = RAM[off[..:2]], error=0. The value is sampled when entering RESP.
//   - Write OK: RAM word written once, on the edge entering RESP. Response has rdata=0, error=0.
//     A same-address read accepted later returns the new data.
//   - Writes always produce a response. Initiators may ignore write responses (fire-and-forget A/D updates):
//     ready reasserts only after the RESP cycle, so a stale write response never overlaps a new request's response.
//   - RESP -> IDLE unconditionally after one cycle. Back-to-back throughput: one request per LATENCY+1 cycles.
//   - A req.valid held through WAIT/RESP is accepted in the next IDLE cycle. addr/wdata changes during busy are ignored.
//   - Reset mid-operation: the request is dropped, no response is issued, and a pending write is not committed.
//   - RAM contents are not cleared by reset.
//   - wen=1 to an unaligned address never writes partially.
// STRUCTURE
//   - Shared package (existing): CacheReq, CacheResp, FaultTy (FE_ACCESS_FAULT).
//   - Add to the package: localparam MEMRESP_ERRTY_DEFAULT = FE_ACCESS_FAULT.
//   - Sub-module mem_word_ram: single-port, WORD_COUNT x 32, synchronous write, registered read.
//     Instantiated once; the FSM drives its address/wen.
//   - Counter width: $clog2(LATENCY)+1 bits.
// TESTING
//   1. Reset: hold reset_n=0 for 3 cycles with req.valid=1 -> resp.valid=0 and no accept throughout;
//      ready=1 on the first cycle after release.
//   2. Write then read, LATENCY=2: write 0x8000_0010 <- 0xDEADBEEF, then read it.
//      -> Read response valid 2 cycles after accept, rdata=0xDEADBEEF, error=0.
//   3. Fault: read 0x8000_0002 and read 0x7FFF_FFFC -> error=1, errty=FE_ACCESS_FAULT, rdata=0.
//      Write 0x8000_4000 (WORD_COUNT=4096) -> fault, and 0x8000_0000 is unchanged.
//   4. Back-to-back: req.valid held high across 4 reads, LATENCY=1 -> accepts every 2nd cycle,
//      4 single-cycle resp pulses, data in order.
//   5. Fire-and-forget: write accepted, initiator drops valid; read issued the same cycle ready returns.
//      -> Exactly one resp per request; the read resp carries the written value.
//   6. Reset mid-WAIT of a write to 0x8000_0020 (prior value 0x1) -> no resp; a later read returns 0x1.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared CacheReq/CacheResp types, fault codes and responder FSM states.
// Latency: n/a (types and pure helper function only).
// Backpressure: n/a.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    FE_ACCESS_FAULT = 2'd0,
    FE_PAGE_FAULT   = 2'd1
  } FaultTy;

  // errty value presented while no fault has been reported yet
  localparam FaultTy MEMRESP_ERRTY_DEFAULT = FE_ACCESS_FAULT;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } CacheReq;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    FaultTy      errty;
  } CacheResp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Unaligned, or outside [base, base+limit). The subtraction wraps for
  // addresses below base, which lands far above limit and so faults too.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] limit);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ({1'b0, off} >= limit);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request and response bundles of the CacheReq/CacheResp protocol.
// Latency: n/a (wiring only).
// Backpressure: request side uses valid/ready; response side has none.
//   cache_req_if : valid, addr, wen, wdata (initiator -> responder), ready (back)
//   cache_resp_if: valid, rdata, error, errty (responder -> initiator)
interface cache_req_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;

  modport master (output valid, addr, wen, wdata, input ready);
  modport slave  (input valid, addr, wen, wdata, output ready);
endinterface

interface cache_resp_if;
  import mem_responder_pkg::*;

  logic        valid;
  logic [31:0] rdata;
  logic        error;
  FaultTy      errty;

  modport master (input valid, rdata, error, errty);
  modport slave  (output valid, rdata, error, errty);
endinterface

// File: rtl/mem_word_ram.sv
// Single-port WORD_COUNT x 32 word RAM, synchronous write, registered read.
// Latency: read data appears one cycle after re; write lands on the we edge.
// Backpressure: none; always accepts an access.
//   clk, we, re, addr[AW-1:0], wdata[31:0] in; rdata[31:0] out
module mem_word_ram #(
  parameter int unsigned WORD_COUNT = 4096,
  localparam int unsigned AW = $clog2(WORD_COUNT)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORD_COUNT];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Backing-store responder: one request at a time served from a word RAM, access faults for bad addresses.
// Latency: accept at edge N -> resp.valid for one cycle after edge N+LATENCY-1.
// Backpressure: req.ready only in IDLE; resp has none, so one request per LATENCY+1 cycles.
//   clk, reset_n (synchronous, active-low)
//   req  : cache_req_if.slave  (valid/addr/wen/wdata in, ready out)
//   resp : cache_resp_if.slave (valid/rdata/error/errty out)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned WORD_COUNT = 4096,
  parameter int unsigned LATENCY    = 2
) (
  input  logic clk,
  input  logic reset_n,
  cache_req_if.slave  req,
  cache_resp_if.slave resp
);

  localparam int unsigned AW = $clog2(WORD_COUNT);
  localparam int unsigned CW = $clog2(LATENCY) + 1;
  localparam logic [32:0] LIMIT = 33'(WORD_COUNT) << 2;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  CacheReq       req_q;
  logic          rd_ok_q;
  logic          error_q;
  FaultTy        errty_q;

  logic [31:0]   cur_addr;
  logic          cur_wen;
  logic [31:0]   cur_wdata;
  logic          cur_fault;
  logic          enter_resp;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // With LATENCY==1 the accept edge is also the RESP-entry edge, so the
  // RAM must see the live request fields in IDLE instead of the latched copy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_addr  = req_q.addr;
    cur_wen   = req_q.wen;
    cur_wdata = req_q.wdata;
    unique case (state_q)
      IDLE: begin
        cur_addr  = req.addr;
        cur_wen   = req.wen;
        cur_wdata = req.wdata;
        if (req.valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cur_fault = addr_fault(cur_addr, ADDR_BASE, LIMIT);
    // Gate with reset_n so a request interrupted by reset never commits.
    enter_resp = reset_n && (state_d == RESP) && (state_q != RESP);
    ram_we     = enter_resp && cur_wen && !cur_fault;
    ram_addr   = AW'((cur_addr - ADDR_BASE) >> 2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_ok_q <= 1'b0;
      error_q <= 1'b0;
      errty_q <= MEMRESP_ERRTY_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req.valid) begin
        req_q <= '{addr: req.addr, wen: req.wen, wdata: req.wdata};
      end
      if (enter_resp) begin
        rd_ok_q <= !cur_wen && !cur_fault;
        error_q <= cur_fault;
        errty_q <= FE_ACCESS_FAULT;
      end
    end
  end

  mem_word_ram #(.WORD_COUNT(WORD_COUNT)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (enter_resp),
    .addr  (ram_addr),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign req.ready   = (state_q == IDLE);
  assign resp.valid  = (state_q == RESP);
  // Writes and faults return zero data; only a clean read exposes the RAM word.
  assign resp.rdata  = rd_ok_q ? ram_rdata : '0;
  assign resp.error  = error_q;
  assign resp.errty  = errty_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven by request tasks.
// Latency: responses checked against accept cycle + LATENCY.
// Backpressure: requests wait on req.ready with bounded loops.
module tb_mem_responder;
  import mem_responder_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    int          due;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_req_if  rq1 ();
  cache_resp_if rs1 ();
  cache_req_if  rq2 ();
  cache_resp_if rs2 ();

  mem_responder #(.ADDR_BASE(32'h8000_0000), .WORD_COUNT(4096), .LATENCY(2)) u_dut2 (
    .clk (clk), .reset_n (reset_n), .req (rq2), .resp (rs2));
  mem_responder #(.ADDR_BASE(32'h8000_0000), .WORD_COUNT(4096), .LATENCY(1)) u_dut1 (
    .clk (clk), .reset_n (reset_n), .req (rq1), .resp (rs1));

  txn_t        q1[$], q2[$];
  int          acc1[$], acc2[$];
  logic [31:0] m1 [bit [31:0]];
  logic [31:0] m2 [bit [31:0]];
  int          n_resp1 = 0, n_resp2 = 0;
  logic [31:0] last_rdata2;
  logic        last_err2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // Independent address legality model: 16 KiB window starting at 0x8000_0000.
  function automatic logic mdl_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h8000_0000) || (a >= 32'h8000_4000);
  endfunction

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin : mon2
    txn_t t;
    logic f;
    logic [31:0] ed;
    if (!reset_n) begin
      q2.delete();
      if (rs2.valid) chk("d2_resp_in_reset", 1, 0);
    end else begin
      if (rs2.valid) begin
        n_resp2++;
        if (q2.size() == 0) chk("d2_spurious_resp", 1, 0);
        else begin
          t  = q2.pop_front();
          f  = mdl_fault(t.addr);
          ed = (f || t.wen) ? 32'h0 : (m2.exists(t.addr) ? m2[t.addr] : 32'h0);
          chk("d2_latency", cyc, t.due);
          chk("d2_error", {31'h0, rs2.error}, {31'h0, f});
          chk("d2_rdata", rs2.rdata, ed);
          if (f) chk("d2_errty", {30'h0, rs2.errty}, {30'h0, FE_ACCESS_FAULT});
          if (!f && t.wen) m2[t.addr] = t.wdata;
          last_rdata2 = rs2.rdata;
          last_err2   = rs2.error;
        end
      end
      if (rq2.valid && rq2.ready) begin
        q2.push_back('{addr: rq2.addr, wen: rq2.wen, wdata: rq2.wdata, due: cyc + 2});
        acc2.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    txn_t t;
    logic f;
    logic [31:0] ed;
    if (!reset_n) begin
      q1.delete();
      if (rs1.valid) chk("d1_resp_in_reset", 1, 0);
    end else begin
      if (rs1.valid) begin
        n_resp1++;
        if (q1.size() == 0) chk("d1_spurious_resp", 1, 0);
        else begin
          t  = q1.pop_front();
          f  = mdl_fault(t.addr);
          ed = (f || t.wen) ? 32'h0 : (m1.exists(t.addr) ? m1[t.addr] : 32'h0);
          chk("d1_latency", cyc, t.due);
          chk("d1_error", {31'h0, rs1.error}, {31'h0, f});
          chk("d1_rdata", rs1.rdata, ed);
          if (!f && t.wen) m1[t.addr] = t.wdata;
        end
      end
      if (rq1.valid && rq1.ready) begin
        q1.push_back('{addr: rq1.addr, wen: rq1.wen, wdata: rq1.wdata, due: cyc + 1});
        acc1.push_back(cyc);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_req(input int sel, input logic v, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
    if (sel == 1) begin
      rq1.valid = v; rq1.addr = a; rq1.wen = w; rq1.wdata = d;
    end else begin
      rq2.valid = v; rq2.addr = a; rq2.wen = w; rq2.wdata = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? rq1.ready : rq2.ready;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 1) ? q1.size() : q2.size();
  endfunction

  // Returns #1 after the accepting edge.
  task automatic wait_ready(input int sel);
    logic got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin got = 1'b1; break; end
    end
    if (!got) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input int sel, input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge clk); #1;
    set_req(sel, 1'b1, a, w, d);
    wait_ready(sel);
    set_req(sel, 1'b0, a, w, d);
  endtask

  task automatic drain(input int sel);
    logic done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (qsize(sel) == 0 && rdy(sel)) begin done = 1'b1; break; end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running want finished");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int r0;
    reset_n = 1'b0;
    set_req(1, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
    set_req(2, 1'b1, 32'h8000_0000, 1'b1, 32'h5555_5555);

    // 1. reset held with valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_vld2", {31'h0, rs2.valid}, 0);
      chk("rst_vld1", {31'h0, rs1.valid}, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(2, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_ready2", {31'h0, rq2.ready}, 1);
    chk("rst_ready1", {31'h0, rq1.ready}, 1);
    chk("rst_vld2_after", {31'h0, rs2.valid}, 0);
    chk("rst_rdata2", rs2.rdata, 0);
    chk("rst_error2", {31'h0, rs2.error}, 0);
    chk("rst_errty2", {30'h0, rs2.errty}, {30'h0, FE_ACCESS_FAULT});

    // 2. write then read, LATENCY 2
    send(2, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF); drain(2);
    send(2, 32'h8000_0010, 1'b0, 32'h0);         drain(2);
    chk("t2_rdata", last_rdata2, 32'hDEAD_BEEF);
    chk("t2_error", {31'h0, last_err2}, 0);

    // 3. faults and boundaries
    send(2, 32'h8000_0000, 1'b1, 32'h1234_5678); drain(2);
    send(2, 32'h8000_0002, 1'b0, 32'h0);         drain(2);
    chk("t3_unaligned_err", {31'h0, last_err2}, 1);
    send(2, 32'h7FFF_FFFC, 1'b0, 32'h0);         drain(2);
    chk("t3_below_err", {31'h0, last_err2}, 1);
    chk("t3_below_rdata", last_rdata2, 0);
    send(2, 32'h8000_4000, 1'b1, 32'hFFFF_FFFF); drain(2);
    chk("t3_above_err", {31'h0, last_err2}, 1);
    send(2, 32'h8000_0001, 1'b1, 32'hFFFF_FFFF); drain(2);
    send(2, 32'h8000_0000, 1'b0, 32'h0);         drain(2);
    chk("t3_word0_kept", last_rdata2, 32'h1234_5678);
    send(2, 32'h8000_3FFC, 1'b1, 32'h0BAD_F00D); drain(2);
    send(2, 32'h8000_3FFC, 1'b0, 32'h0);         drain(2);
    chk("t3_last_word", last_rdata2, 32'h0BAD_F00D);
    chk("t3_last_err", {31'h0, last_err2}, 0);

    // 4. back-to-back with valid held, LATENCY 1
    for (int i = 0; i < 4; i++) begin
      send(1, 32'h8000_0100 + 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i));
      drain(1);
    end
    r0 = n_resp1;
    acc1.delete();
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ready(1);
      if (i < 3) set_req(1, 1'b1, 32'h8000_0104 + 32'(4 * i), 1'b0, 32'h0);
      else       set_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    drain(1);
    chk("t4_nresp", n_resp1 - r0, 4);
    chk("t4_naccept", acc1.size(), 4);
    for (int i = 1; i < acc1.size(); i++) chk("t4_gap", acc1[i] - acc1[i-1], 2);

    // 5. fire-and-forget write, read waiting for ready to return
    r0 = n_resp2;
    acc2.delete();
    @(posedge clk); #1;
    set_req(2, 1'b1, 32'h8000_0040, 1'b1, 32'hCAFE_0042);
    wait_ready(2);
    set_req(2, 1'b1, 32'h8000_0040, 1'b0, 32'h0);
    wait_ready(2);
    set_req(2, 1'b0, 32'h0, 1'b0, 32'h0);
    drain(2);
    chk("t5_nresp", n_resp2 - r0, 2);
    chk("t5_naccept", acc2.size(), 2);
    if (acc2.size() == 2) chk("t5_gap", acc2[1] - acc2[0], 3);
    chk("t5_rdata", last_rdata2, 32'hCAFE_0042);

    // 6. reset in WAIT of a write drops it
    send(2, 32'h8000_0020, 1'b1, 32'h0000_0001); drain(2);
    r0 = n_resp2;
    @(posedge clk); #1;
    set_req(2, 1'b1, 32'h8000_0020, 1'b1, 32'h0000_0BAD);
    wait_ready(2);
    set_req(2, 1'b0, 32'h0, 1'b0, 32'h0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_resp", n_resp2 - r0, 0);
    send(2, 32'h8000_0020, 1'b0, 32'h0); drain(2);
    chk("t6_rdata", last_rdata2, 32'h0000_0001);

    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
